ccff_chain_loader: RTL and testbench

- Configuration controller that serially loads a bitstream into a tile's configuration-chain flops (ccff_head → … → ccff_tail) clocked by prog_clk.
- Accepts bitstream words from a valid/ready source, serialises them LSB-first and asserts a shift enable for an external prog_clk gate, so the chain advances only on real bits.
- Counts chain bits, reports done, flags source starvation with an error, and accumulates parity of the previous contents shifted out of ccff_tail.

---
 rtl/ccff_chain_loader.sv | 163 ++++++++++++++++
 tb/tb_ccff_chain_loader.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ccff_chain_loader.sv
// ---------------------------------------------------------------------------
// ccff_chain_loader
//
// Loads a tile's configuration chain (ccff_head -> ... -> ccff_tail) from a
// stream of bitstream words. Each accepted word is shifted into the chain
// LSB-first. cfg_clk_en gates the external prog_clk of the chain flops, so
// the chain only advances on cycles that carry a real configuration bit.
// The previous chain contents leaving on ccff_tail are folded into a parity.
//
// Handshake: a word transfers on every prog_clk edge where word_valid and
// word_ready are both high. word_ready depends only on controller state, so
// the source may assert word_valid at any time and must hold word_data
// stable until the transfer edge.
//
// Ports
//   prog_clk     configuration clock (only clock)
//   prog_reset   asynchronous active-low reset
//   start        begin a load (honoured in IDLE/DONE/ERR)
//   abort        return to IDLE on the next edge, from any state
//   word_data    bitstream word, bit 0 shifted first
//   word_valid   word_data valid
//   word_ready   controller accepts a word this cycle
//   ccff_head    serial bit into the chain
//   ccff_tail    serial bit out of the chain
//   cfg_clk_en   chain shift enable
//   busy         loading (LOAD or SHIFT)
//   done         load complete (level)
//   error        source starvation timeout (level)
//   bit_count    bits shifted in the current/last load
//   tail_parity  XOR of ccff_tail over every enabled shift of this load
//   dbg_state_o  current FSM state (debug)
// ---------------------------------------------------------------------------
module ccff_chain_loader #(
    parameter int CHAIN_LEN = 20,
    parameter int WORD_W    = 8,
    parameter int TIMEOUT   = 64,
    parameter int CNT_W     = 16
) (
    input  logic              prog_clk,
    input  logic              prog_reset,
    input  logic              start,
    input  logic              abort,
    input  logic [WORD_W-1:0] word_data,
    input  logic              word_valid,
    output logic              word_ready,
    output logic              ccff_head,
    input  logic              ccff_tail,
    output logic              cfg_clk_en,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [CNT_W-1:0]  bit_count,
    output logic              tail_parity,
    output logic [2:0]        dbg_state_o
);

    localparam int RW = $clog2(WORD_W + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_SHIFT = 3'd2,
        S_DONE  = 3'd3,
        S_ERR   = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [WORD_W-1:0] sr_q, sr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              par_q, par_d;
    logic [TW-1:0]     tmo_q, tmo_d;
    logic [RW-1:0]     rem_q, rem_d;

    logic [CNT_W-1:0]  bits_left;
    logic [RW-1:0]     n_word;

    // Shift length for the word being accepted: the final word may only be
    // partially used, its high bits are never shifted.
    assign bits_left = CNT_W'(CHAIN_LEN) - cnt_q;
    assign n_word    = (32'(bits_left) < 32'(WORD_W)) ? RW'(bits_left) : RW'(WORD_W);

    always_ff @(posedge prog_clk or negedge prog_reset) begin
        if (!prog_reset) begin
            state_q <= S_IDLE;
            sr_q    <= '0;
            cnt_q   <= '0;
            par_q   <= 1'b0;
            tmo_q   <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            par_q   <= par_d;
            tmo_q   <= tmo_d;
            rem_q   <= rem_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        par_d   = par_q;
        tmo_d   = tmo_q;
        rem_d   = rem_q;

        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                // abort outranks start, so counters are not cleared then
                if (start && !abort) begin
                    state_d = S_LOAD;
                    cnt_d   = '0;
                    par_d   = 1'b0;
                    tmo_d   = '0;
                end
            end
            S_LOAD: begin
                if (word_valid) begin
                    sr_d    = word_data;
                    rem_d   = n_word;
                    tmo_d   = '0;
                    state_d = S_SHIFT;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                    if (tmo_d == TW'(TIMEOUT)) begin
                        state_d = S_ERR;
                    end
                end
            end
            S_SHIFT: begin
                // The chain moves on this edge regardless of abort, so the
                // bookkeeping for this bit is always taken.
                sr_d  = sr_q >> 1;
                cnt_d = cnt_q + CNT_W'(1);
                par_d = par_q ^ ccff_tail;
                rem_d = rem_q - RW'(1);
                if (rem_q == RW'(1)) begin
                    state_d = (cnt_d == CNT_W'(CHAIN_LEN)) ? S_DONE : S_LOAD;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (abort) begin
            state_d = S_IDLE;
        end
    end

    // Head and enable both decode from registered state, so they switch on
    // the same edge and the enable drops asynchronously with reset.
    assign word_ready  = (state_q == S_LOAD);
    assign cfg_clk_en  = (state_q == S_SHIFT);
    assign ccff_head   = (state_q == S_SHIFT) & sr_q[0];
    assign busy        = (state_q == S_LOAD) | (state_q == S_SHIFT);
    assign done        = (state_q == S_DONE);
    assign error       = (state_q == S_ERR);
    assign bit_count   = cnt_q;
    assign tail_parity = par_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_ccff_chain_loader.sv
module tb_ccff_chain_loader;

  localparam int L  = 20;
  localparam int W  = 8;
  localparam int CW = 16;
  localparam int NW = (L + W - 1) / W;

  // ---------------- clock / reset ----------------
  logic prog_clk = 1'b0;
  logic prog_reset = 1'b0;
  always #5 prog_clk = ~prog_clk;

  // ---------------- instance a (defaults) ----------------
  logic          start = 1'b0, abort = 1'b0, word_valid = 1'b0;
  logic [W-1:0]  word_data = '0;
  logic          word_ready, ccff_head, ccff_tail, cfg_clk_en, busy, done, error, tail_parity;
  logic [CW-1:0] bit_count;
  logic [2:0]    dbg_state;

  ccff_chain_loader dut (
    .prog_clk(prog_clk), .prog_reset(prog_reset), .start(start), .abort(abort),
    .word_data(word_data), .word_valid(word_valid), .word_ready(word_ready),
    .ccff_head(ccff_head), .ccff_tail(ccff_tail), .cfg_clk_en(cfg_clk_en),
    .busy(busy), .done(done), .error(error), .bit_count(bit_count),
    .tail_parity(tail_parity), .dbg_state_o(dbg_state)
  );

  // ---------------- instance b (8-bit chain, one word) ----------------
  logic          start_b = 1'b0, abort_b = 1'b0, word_valid_b = 1'b0, tail_b = 1'b0;
  logic [7:0]    word_data_b = '0;
  logic          word_ready_b, ccff_head_b, cfg_clk_en_b, busy_b, done_b, error_b, tail_parity_b;
  logic [CW-1:0] bit_count_b;
  logic [2:0]    dbg_state_b;

  ccff_chain_loader #(.CHAIN_LEN(8), .WORD_W(8), .TIMEOUT(64), .CNT_W(16)) dut_b (
    .prog_clk(prog_clk), .prog_reset(prog_reset), .start(start_b), .abort(abort_b),
    .word_data(word_data_b), .word_valid(word_valid_b), .word_ready(word_ready_b),
    .ccff_head(ccff_head_b), .ccff_tail(tail_b), .cfg_clk_en(cfg_clk_en_b),
    .busy(busy_b), .done(done_b), .error(error_b), .bit_count(bit_count_b),
    .tail_parity(tail_parity_b), .dbg_state_o(dbg_state_b)
  );

  // ---------------- chain model and monitors ----------------
  logic [L-1:0] chain_m = '0;
  logic [L-1:0] pre_val = '0;
  logic         load_req = 1'b0;
  logic         en_s = 1'b0, head_s = 1'b0;
  logic         head_q[$];
  int           en_cnt = 0, hs_cnt = 0, cyc = 0;
  logic [7:0]   b_bits = '0;
  int           b_en = 0;

  assign ccff_tail = chain_m[L-1];

  always @(posedge prog_clk) begin
    cyc <= cyc + 1;
    if (load_req) chain_m <= pre_val;
    else if (en_s) chain_m <= {chain_m[L-2:0], head_s};
  end

  always @(negedge prog_clk) begin
    en_s   = cfg_clk_en;
    head_s = ccff_head;
    if (cfg_clk_en) begin
      head_q.push_back(ccff_head);
      en_cnt++;
    end
    if (word_valid && word_ready) hs_cnt++;
    if (cfg_clk_en_b) begin
      b_bits = {ccff_head_b, b_bits[7:1]};
      b_en++;
    end
  end

  // ---------------- scoreboard counters ----------------
  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge prog_clk);
    #1;
  endtask

  task automatic wait_ready(input string tag);
    int k = 0;
    while (!word_ready && k < 100) begin
      tick();
      k++;
    end
    check(tag, word_ready, 1);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // ---------------- stimulus data and reference model ----------------
  logic [W-1:0] words_a [NW];
  int           delays_a[NW];

  // Bit k of the serial stream is bit (k mod W) of word (k div W).
  function automatic logic [L-1:0] model_stream();
    logic [L-1:0] s;
    for (int k = 0; k < L; k++) s[k] = words_a[k / W][k % W];
    return s;
  endfunction

  function automatic int model_cycles();
    int c = 0;
    for (int w = 0; w < NW; w++) begin
      int n = (W < L - w * W) ? W : L - w * W;
      c += n + 1 + delays_a[w];
    end
    return c;
  endfunction

  task automatic run_load(input string tag, input logic [L-1:0] pre, input bit inj_start,
                          output logic [L-1:0] got_seq);
    int base_h, base_e, base_hs, t0, k;
    logic [L-1:0] exp_seq, exp_chain;
    pre_val  = pre;
    load_req = 1'b1;
    tick();
    load_req = 1'b0;
    base_h  = head_q.size();
    base_e  = en_cnt;
    base_hs = hs_cnt;
    pulse_start();
    t0 = cyc;
    check({tag, "_start_done"}, done, 0);
    check({tag, "_start_err"}, error, 0);
    check({tag, "_start_cnt"}, bit_count, 0);
    check({tag, "_start_par"}, tail_parity, 0);
    for (int w = 0; w < NW; w++) begin
      wait_ready({tag, "_ready"});
      repeat (delays_a[w]) tick();
      word_data  = words_a[w];
      word_valid = 1'b1;
      tick();
      word_valid = 1'b0;
      word_data  = W'($urandom);
      if (w == 0 && inj_start) begin
        start = 1'b1;
        tick();
        start = 1'b0;
        check({tag, "_inj_cnt"}, bit_count, 1);
        check({tag, "_inj_busy"}, busy, 1);
      end
    end
    k = 0;
    while (!done && k < 100) begin
      tick();
      k++;
    end
    exp_seq = model_stream();
    for (int i = 0; i < L; i++) begin
      got_seq[i] = (base_h + i < head_q.size()) ? head_q[base_h + i] : 1'bx;
      exp_chain[L - 1 - i] = exp_seq[i];
    end
    check({tag, "_done"}, done, 1);
    check({tag, "_error"}, error, 0);
    check({tag, "_en_off"}, cfg_clk_en, 0);
    check({tag, "_ready_off"}, word_ready, 0);
    check({tag, "_bit_count"}, bit_count, L);
    check({tag, "_en_cycles"}, en_cnt - base_e, L);
    check({tag, "_handshakes"}, hs_cnt - base_hs, NW);
    check({tag, "_load_cycles"}, cyc - t0, model_cycles());
    check({tag, "_head_seq"}, got_seq, exp_seq);
    check({tag, "_chain"}, chain_m, exp_chain);
    check({tag, "_parity"}, tail_parity, ^pre);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [L-1:0] seq;
    int k;

    // reset state
    #1;
    check("rst_ready", word_ready, 0);
    check("rst_head", ccff_head, 0);
    check("rst_en", cfg_clk_en, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    check("rst_count", bit_count, 0);
    check("rst_parity", tail_parity, 0);
    repeat (3) @(negedge prog_clk);
    prog_reset = 1'b1;
    tick();

    // single-word chain: exactly 8 shifts, then no further words accepted
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    check("b_ready", word_ready_b, 1);
    word_data_b  = 8'h96;
    word_valid_b = 1'b1;
    tick();
    word_valid_b = 1'b0;
    word_data_b  = 8'h5A;
    k = 0;
    while (!done_b && k < 40) begin
      tick();
      k++;
    end
    check("b_done", done_b, 1);
    check("b_count", bit_count_b, 8);
    check("b_en_cycles", b_en, 8);
    check("b_head_bits", b_bits, 8'h96);
    word_valid_b = 1'b1;
    repeat (3) begin
      tick();
      check("b_extra_ready", word_ready_b, 0);
    end
    check("b_count_hold", bit_count_b, 8);
    word_valid_b = 1'b0;

    // directed stream, chain preloaded with ones
    words_a[0] = 8'hA5; words_a[1] = 8'h3C; words_a[2] = 8'h0F;
    delays_a[0] = 0; delays_a[1] = 0; delays_a[2] = 0;
    run_load("plan_ones", {L{1'b1}}, 1'b0, seq);
    check("plan_seq_const", seq, 20'hF3CA5);
    run_load("plan_one_zero", 20'hFFFFE, 1'b0, seq);

    // 63 idle LOAD cycles are tolerated
    words_a[0] = W'($urandom); words_a[1] = W'($urandom); words_a[2] = W'($urandom);
    delays_a[1] = 63;
    run_load("idle63", L'($urandom), 1'b0, seq);

    // 64 idle LOAD cycles starve the controller
    pulse_start();
    check("tmo_start_done", done, 0);
    wait_ready("tmo_ready1");
    word_data  = W'($urandom);
    word_valid = 1'b1;
    tick();
    word_valid = 1'b0;
    wait_ready("tmo_ready2");
    repeat (63) tick();
    check("tmo_63_error", error, 0);
    check("tmo_63_ready", word_ready, 1);
    tick();
    check("tmo_64_error", error, 1);
    check("tmo_64_count", bit_count, 8);
    check("tmo_64_en", cfg_clk_en, 0);
    check("tmo_64_busy", busy, 0);
    check("tmo_64_ready", word_ready, 0);

    // from ERR, start pulsed during SHIFT must not disturb the load
    for (int w = 0; w < NW; w++) begin
      words_a[w] = W'($urandom);
      delays_a[w] = 0;
    end
    run_load("inj_start", L'($urandom), 1'b1, seq);

    // randomized loads
    for (int r = 0; r < 6; r++) begin
      for (int w = 0; w < NW; w++) begin
        words_a[w]  = W'($urandom);
        delays_a[w] = $urandom_range(0, 6);
      end
      run_load("rand", L'($urandom), 1'b0, seq);
    end

    // abort at the 5th shift cycle of word 2
    pulse_start();
    wait_ready("abt_ready1");
    word_data  = W'($urandom);
    word_valid = 1'b1;
    tick();
    word_valid = 1'b0;
    wait_ready("abt_ready2");
    word_data  = W'($urandom);
    word_valid = 1'b1;
    tick();
    word_valid = 1'b0;
    repeat (4) tick();
    check("abt_pre_en", cfg_clk_en, 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abt_en", cfg_clk_en, 0);
    check("abt_busy", busy, 0);
    check("abt_count", bit_count, 13);
    check("abt_done", done, 0);
    repeat (2) tick();
    check("abt_count_hold", bit_count, 13);
    pulse_start();
    check("abt_restart_count", bit_count, 0);
    check("abt_restart_ready", word_ready, 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abt2_busy", busy, 0);

    // asynchronous reset in the middle of a shift burst
    pulse_start();
    wait_ready("rst_mid_ready");
    word_data  = W'($urandom);
    word_valid = 1'b1;
    tick();
    word_valid = 1'b0;
    tick();
    check("rst_mid_pre_en", cfg_clk_en, 1);
    #2;
    prog_reset = 1'b0;
    #1;
    check("rst_mid_en", cfg_clk_en, 0);
    check("rst_mid_head", ccff_head, 0);
    check("rst_mid_count", bit_count, 0);
    check("rst_mid_busy", busy, 0);
    @(negedge prog_clk);
    prog_reset = 1'b1;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
